// File: rtl/alu_result_display.sv
// Display stage for the 4-bit ALU: sequential double-dabble of the 8-bit result
// into signed decimal, shown on a 4-digit multiplexed common-anode 7-segment display.
module alu_result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  Din,
    input  logic [1:0]  Fsel,
    output logic [11:0] Bcd,
    output logic        Neg,
    output logic        Valid,
    output logic        Busy,
    output logic [3:0]  AN,
    output logic [6:0]  SEG
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      shift_cnt;
    logic            neg_pend;
    logic            done_en;
    logic [7:0]      mag_r;
    logic [11:0]     bcd_sr;
    logic [11:0]     bcd_adj;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]      digit_idx;
    logic [6:0]      seg_nxt;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return GLYPH_BLANK;
        endcase
    endfunction

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_LOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (shift_cnt == 3'd7) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        Busy    = (state != S_DONE);
        done_en = (state == S_DONE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            shift_cnt <= 3'd0;
            neg_pend  <= 1'b0;
        end else if (state == S_LOAD) begin
            shift_cnt <= 3'd0;
            neg_pend  <= (Fsel == 2'b01) && Din[7];
        end else if (state == S_SHIFT) begin
            shift_cnt <= shift_cnt + 3'd1;
        end
    end

    assign bcd_adj = {add3(bcd_sr[11:8]), add3(bcd_sr[7:4]), add3(bcd_sr[3:0])};

    // Conversion datapath: fully reloaded every LOAD, so it carries no reset.
    always_ff @(posedge Clk) begin
        if (state == S_LOAD) begin
            mag_r  <= ((Fsel == 2'b01) && Din[7]) ? (~Din + 8'd1) : Din;
            bcd_sr <= 12'd0;
        end else if (state == S_SHIFT) begin
            {bcd_sr, mag_r} <= {bcd_adj[10:0], mag_r, 1'b0};
        end
    end

    // A zero magnitude never shows a sign, whatever produced it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Bcd   <= 12'd0;
            Neg   <= 1'b0;
            Valid <= 1'b0;
        end else begin
            Valid <= done_en;
            if (done_en) begin
                Bcd <= bcd_sr;
                Neg <= neg_pend && (bcd_sr != 12'd0);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            div_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        seg_nxt = GLYPH_BLANK;
        case (digit_idx)
            2'd0: seg_nxt = glyph(Bcd[3:0]);
            2'd1: seg_nxt = (Bcd[11:4] == 8'd0) ? GLYPH_BLANK : glyph(Bcd[7:4]);
            2'd2: seg_nxt = (Bcd[11:8] == 4'd0) ? GLYPH_BLANK : glyph(Bcd[11:8]);
            2'd3: seg_nxt = Neg ? GLYPH_MINUS : GLYPH_BLANK;
            default: seg_nxt = GLYPH_BLANK;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            AN  <= 4'b1111;
            SEG <= GLYPH_BLANK;
        end else begin
            AN  <= ~(4'b0001 << digit_idx);
            SEG <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboarded bench for alu_result_display: directed ALU results, expected
// {Neg,Bcd} queued at issue and compared by a monitor on each Valid pulse.
module tb_alu_result_display;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [7:0]  Din = 8'h00;
    logic [1:0]  Fsel = 2'b00;
    logic [11:0] Bcd;
    logic        Neg;
    logic        Valid;
    logic        Busy;
    logic [3:0]  AN;
    logic [6:0]  SEG;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];
    logic prev_busy = 1'b1;
    logic prev_valid = 1'b0;
    logic [6:0] seen[4];
    logic an_bad;

    localparam logic [6:0] G_BL = 7'b1111111;
    localparam logic [6:0] G_MI = 7'b0111111;
    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000;

    alu_result_display #(.SCAN_DIV(4)) dut (
        .Clk(Clk), .Rst(Rst), .Din(Din), .Fsel(Fsel),
        .Bcd(Bcd), .Neg(Neg), .Valid(Valid), .Busy(Busy),
        .AN(AN), .SEG(SEG)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst && Valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got Bcd %h want none", Bcd);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                chk("bcd", {4'h0, Bcd}, {4'h0, e[11:0]});
                chk("neg", {15'h0, Neg}, {15'h0, e[12]});
            end
            chk("busy_low_before_valid", {15'h0, prev_busy}, 16'h0);
            chk("valid_one_cycle", {15'h0, prev_valid}, 16'h0);
        end
        prev_busy  = Busy;
        prev_valid = Valid;
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Valid && n < 40);
        if (!Valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout got %0d cycles want <40", n);
        end
    endtask

    task automatic sample_display();
        for (int d = 0; d < 4; d++) seen[d] = 'x;
        an_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            case (AN)
                4'b1110: seen[0] = SEG;
                4'b1101: seen[1] = SEG;
                4'b1011: seen[2] = SEG;
                4'b0111: seen[3] = SEG;
                default: an_bad = 1'b1;
            endcase
        end
    endtask

    // Call only right after a Valid, so the next LOAD samples the new inputs.
    task automatic run_vec(input string name, input logic [7:0] din, input logic [1:0] fsel,
                           input logic [11:0] eb, input logic en,
                           input logic [6:0] g0, input logic [6:0] g1,
                           input logic [6:0] g2, input logic [6:0] g3);
        int n;
        Din  = din;
        Fsel = fsel;
        exp_q.push_back({en, eb});
        wait_valid(n);
        @(negedge Clk);
        fork
            begin
                int m;
                exp_q.push_back({en, eb});
                wait_valid(m);
                exp_q.push_back({en, eb});
                wait_valid(m);
            end
            sample_display();
        join
        chk({name, "_an_onehot"}, {15'h0, an_bad}, 16'h0);
        chk({name, "_dig0"}, {9'h0, seen[0]}, {9'h0, g0});
        chk({name, "_dig1"}, {9'h0, seen[1]}, {9'h0, g1});
        chk({name, "_dig2"}, {9'h0, seen[2]}, {9'h0, g2});
        chk({name, "_dig3"}, {9'h0, seen[3]}, {9'h0, g3});
    endtask

    initial begin
        int n;
        Din  = 8'h0F;
        Fsel = 2'b00;
        repeat (3) @(negedge Clk);
        chk("rst_an",    {12'h0, AN},  16'h000F);
        chk("rst_seg",   {9'h0, SEG},  {9'h0, G_BL});
        chk("rst_bcd",   {4'h0, Bcd},  16'h0000);
        chk("rst_valid", {15'h0, Valid}, 16'h0);
        chk("rst_busy",  {15'h0, Busy},  16'h1);
        exp_q.push_back({1'b0, 12'h015});
        Rst = 1'b1;
        wait_valid(n);
        chk("first_valid_latency", 16'(n), 16'd10);

        run_vec("add_0f",    8'h0F, 2'b00, 12'h015, 1'b0, G5, G1, G_BL, G_BL);
        run_vec("sub_f9",    8'hF9, 2'b01, 12'h007, 1'b1, G7, G_BL, G_BL, G_MI);
        run_vec("uns_f9",    8'hF9, 2'b00, 12'h249, 1'b0, G9, G4, G2, G_BL);
        run_vec("uns_e1",    8'hE1, 2'b10, 12'h225, 1'b0, G5, G2, G2, G_BL);
        run_vec("zero_sub",  8'h00, 2'b01, 12'h000, 1'b0, G0, G_BL, G_BL, G_BL);
        run_vec("min_neg",   8'h80, 2'b01, 12'h128, 1'b1, G8, G2, G1, G_MI);

        // Din changes mid-SHIFT: this pass still reports the old value.
        Din  = 8'h0F;
        Fsel = 2'b00;
        exp_q.push_back({1'b0, 12'h015});
        repeat (4) @(negedge Clk);
        Din = 8'h1E;
        wait_valid(n);
        exp_q.push_back({1'b0, 12'h030});
        wait_valid(n);

        // Asynchronous reset in the middle of a pass.
        repeat (4) @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("midrst_an",    {12'h0, AN},  16'h000F);
        chk("midrst_seg",   {9'h0, SEG},  {9'h0, G_BL});
        chk("midrst_bcd",   {4'h0, Bcd},  16'h0000);
        chk("midrst_neg",   {15'h0, Neg}, 16'h0);
        chk("midrst_valid", {15'h0, Valid}, 16'h0);
        chk("midrst_busy",  {15'h0, Busy},  16'h1);
        exp_q.delete();
        repeat (2) @(negedge Clk);
        Din  = 8'hF9;
        Fsel = 2'b01;
        exp_q.push_back({1'b1, 12'h007});
        Rst = 1'b1;
        wait_valid(n);
        chk("post_rst_latency", 16'(n), 16'd10);

        @(negedge Clk);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
